multicycle_controls: RTL and testbench
======================================

// Module: multicycle_controls
// PURPOSE
//  Multi-cycle main control FSM for the MIPS-subset datapath: ADD/SUB/AND/OR/SLT, ADDI, LW, SW, BEQ, BNE, J.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath enable per state.
//  Stalls on a req/ready handshake with unified instruction/data memory and flags illegal opcodes.
//  Sits between instruction register (opcode/funct) and datapath muxes, register file, ALU and memory port.
// PARAMETERS
//  OPCODE_W  6  opcode field width
//  FUNCT_W   6  funct field width
//  ALUOP_W   4  ALU control code width (codes below need >=3; upper bits zero)
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         synchronous active-low reset
//  opcode       in   OPCODE_W  IR[31:26], valid from DECODE onward
//  funct        in   FUNCT_W   IR[5:0], valid from DECODE onward
//  memReady     in   1         memory completes the access this cycle
//  memReq       out  1         memory access request (= memRead | memWrite)
//  memRead      out  1         read from memory
//  memWrite     out  1         write to memory
//  iorD         out  1         0: address from PC, 1: address from ALUOut
//  irWrite      out  1         latch instruction register
//  pcWrite      out  1         unconditional PC load
//  pcWriteCond  out  1         PC load if ALU zero == !branchNe
//  branchNe     out  1         invert zero test (BNE)
//  pcSource     out  2         00 ALU, 01 ALUOut (branch target), 10 jump target
//  aluSrcA      out  1         0: PC, 1: rs
//  aluSrcB      out  2         00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
//  aluOp        out  ALUOP_W   ALU control: add 0010, sub 0110, and 0000, or 0001, slt 0111
//  regDst       out  1         0: write rt, 1: write rd
//  regWrite     out  1         register file write
//  memToReg     out  1         0: write-back from ALUOut, 1: from MDR
//  illegalOp    out  1         one-cycle pulse, unknown opcode/funct detected in DECODE
//  instrDone    out  1         one-cycle pulse in final state of each retired instruction
// BEHAVIOUR
//  - Moore FSM; outputs decode from state register, plus memReady gating in FETCH/MEMRD/MEMWR.
//  - Reset: rst_n sampled low -> state=FETCH at the edge; while rst_n==0 every output is 0.
//  - Reset mid-instruction abandons it; no partial regWrite/memWrite is issued after the reset edge.
//  - States and transitions:
//    - FETCH: memRead, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=add, pcSource=00.
//      irWrite=pcWrite=memReady; stay while !memReady, else -> DECODE.
//    - DECODE: aluSrcA=0, aluSrcB=11, aluOp=add (precompute branch target). Next state by opcode:
//      00 R-type -> REXEC (illegal funct -> FETCH + illegalOp)
//      08 -> IEXEC; 23/2B -> MEMADDR; 04/05 -> BRANCH; 02 -> JUMP; other -> FETCH + illegalOp.
//    - REXEC: aluSrcA=1, aluSrcB=00, aluOp from funct (20 add, 22 sub, 24 and, 25 or, 2A slt) -> RWB.
//    - RWB: regDst=1, regWrite, memToReg=0, instrDone -> FETCH.
//    - IEXEC: aluSrcA=1, aluSrcB=10, aluOp=add -> IWB.
//    - IWB: regDst=0, regWrite, memToReg=0, instrDone -> FETCH.
//    - MEMADDR: aluSrcA=1, aluSrcB=10, aluOp=add -> MEMRD (LW) or MEMWR (SW).
//    - MEMRD: memRead, iorD=1; hold until memReady -> LWB.
//    - MEMWR: memWrite, iorD=1; hold until memReady, then instrDone -> FETCH.
//    - LWB: regDst=0, regWrite, memToReg=1, instrDone -> FETCH.
//    - BRANCH: aluSrcA=1, aluSrcB=00, aluOp=sub, pcWriteCond, pcSource=01, branchNe=(opcode==05), instrDone -> FETCH.
//    - JUMP: pcWrite, pcSource=10, instrDone -> FETCH.
//  - Zero-wait latency in cycles: R/ADDI/SW 4, LW 5, BEQ/BNE/J 3. Each wait cycle of memReady adds 1.
//  - memReq/memRead/memWrite stay high and stable until the memReady cycle; they drop the next cycle.
//  - memReady outside FETCH/MEMRD/MEMWR is ignored.
//  - Unused outputs are 0 in every state (no X).
//  - aluOp is zero-extended to ALUOP_W.
// STRUCTURE
//  - Package mc_ctrl_pkg: state enum, opcode constants, funct constants, ALU control codes, aluSrcB/pcSource encodings.
//  - Sub-module alu_decoder (combinational): funct -> {aluOp, illegal}, used in DECODE/REXEC.
// TESTING
//  1. rst_n=0 for 2 cycles with memReady=1 -> all outputs 0; first cycle after release: FETCH, memRead=1, iorD=0.
//  2. ADD (opcode 00, funct 20), memReady=1 -> irWrite+pcWrite in cycle 1; REXEC aluOp=0010; RWB regDst=1, regWrite=1, instrDone; back to FETCH at cycle 5.
//  3. LW (23) with memReady low 3 cycles in MEMRD -> memRead, iorD=1 held 4 cycles; LWB memToReg=1, regWrite=1; total 8 cycles.
//  4. BNE (05) -> BRANCH: pcWriteCond=1, branchNe=1, aluOp=0110, pcSource=01; BEQ (04) -> same with branchNe=0.
//  5. Opcode 3F, then funct 0x3F with opcode 00 -> illegalOp pulse in DECODE, no regWrite/memWrite, FETCH next cycle.
//  6. rst_n low during MEMWR wait (memReady=0) -> memWrite=0 immediately; FETCH after release; no instrDone.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main control FSM: state enum,
// instruction field constants, ALU control codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_REXEC   = 4'd2,
    S_RWB     = 4'd3,
    S_IEXEC   = 4'd4,
    S_IWB     = 4'd5,
    S_MEMADDR = 4'd6,
    S_MEMRD   = 4'd7,
    S_MEMWR   = 4'd8,
    S_LWB     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Narrowest form of the ALU control codes; zero-extended at the ports.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controls_alu_decoder.sv
// R-type funct field to ALU control code, with an illegal-funct flag.
module alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 4
) (
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic               o_illegal
);

  // Map funct to an ALU code; unknown functs report illegal and yield AND (zero).
  always_comb begin
    o_alu_op  = '0;
    o_illegal = 1'b0;
    case (i_funct)
      FUNCT_W'(FN_ADD): o_alu_op = ALUOP_W'(ALU_ADD);
      FUNCT_W'(FN_SUB): o_alu_op = ALUOP_W'(ALU_SUB);
      FUNCT_W'(FN_AND): o_alu_op = ALUOP_W'(ALU_AND);
      FUNCT_W'(FN_OR):  o_alu_op = ALUOP_W'(ALU_OR);
      FUNCT_W'(FN_SLT): o_alu_op = ALUOP_W'(ALU_SLT);
      default:          o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controls.sv
// Multi-cycle main control FSM for the MIPS-subset datapath.
//
//  state   | meaning
//  FETCH   | read instruction at PC, PC+4; advance on memReady
//  DECODE  | precompute branch target, dispatch on opcode
//  REXEC   | R-type ALU operation rs op rt
//  RWB     | write ALUOut to rd
//  IEXEC   | ADDI rs + imm
//  IWB     | write ALUOut to rt
//  MEMADDR | LW/SW effective address rs + imm
//  MEMRD   | data read at ALUOut; hold until memReady
//  MEMWR   | data write at ALUOut; hold until memReady
//  LWB     | write MDR to rt
//  BRANCH  | compare rs - rt, conditional PC load
//  JUMP    | unconditional PC load from jump target
module multicycle_controls
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUOP_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                memReady,
  output logic                memReq,
  output logic                memRead,
  output logic                memWrite,
  output logic                iorD,
  output logic                irWrite,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic                branchNe,
  output logic [1:0]          pcSource,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [ALUOP_W-1:0]  aluOp,
  output logic                regDst,
  output logic                regWrite,
  output logic                memToReg,
  output logic                illegalOp,
  output logic                instrDone
);

  state_t               r_state;
  state_t               w_next;
  logic [ALUOP_W-1:0]   w_funct_alu_op;
  logic                 w_funct_illegal;
  logic                 w_op_illegal;

  alu_decoder #(
    .FUNCT_W (FUNCT_W),
    .ALUOP_W (ALUOP_W)
  ) u_alu_decoder (
    .i_funct   (funct),
    .o_alu_op  (w_funct_alu_op),
    .o_illegal (w_funct_illegal)
  );

  // Unknown opcode, or an R-type carrying an unknown funct.
  always_comb begin
    w_op_illegal = 1'b0;
    case (opcode)
      OPCODE_W'(OP_RTYPE): w_op_illegal = w_funct_illegal;
      OPCODE_W'(OP_ADDI), OPCODE_W'(OP_LW), OPCODE_W'(OP_SW),
      OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNE), OPCODE_W'(OP_J): w_op_illegal = 1'b0;
      default: w_op_illegal = 1'b1;
    endcase
  end

  // State register; reset returns to FETCH and abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state sequencing; memReady only matters in the three memory states.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_op_illegal) w_next = S_FETCH;
        else begin
          case (opcode)
            OPCODE_W'(OP_RTYPE):                    w_next = S_REXEC;
            OPCODE_W'(OP_ADDI):                     w_next = S_IEXEC;
            OPCODE_W'(OP_LW), OPCODE_W'(OP_SW):     w_next = S_MEMADDR;
            OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNE):   w_next = S_BRANCH;
            OPCODE_W'(OP_J):                        w_next = S_JUMP;
            default:                                w_next = S_FETCH;
          endcase
        end
      end
      S_REXEC:   w_next = S_RWB;
      S_IEXEC:   w_next = S_IWB;
      S_MEMADDR: w_next = (opcode == OPCODE_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = memReady ? S_LWB : S_MEMRD;
      S_MEMWR:   w_next = memReady ? S_FETCH : S_MEMWR;
      default:   w_next = S_FETCH;
    endcase
  end

  // Per-state datapath controls; everything is forced low while reset is asserted.
  always_comb begin
    memRead     = 1'b0;
    memWrite    = 1'b0;
    iorD        = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    branchNe    = 1'b0;
    pcSource    = PCSRC_ALU;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_RT;
    aluOp       = '0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    memToReg    = 1'b0;
    illegalOp   = 1'b0;
    instrDone   = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          memRead = 1'b1;
          aluSrcB = SRCB_FOUR;
          aluOp   = ALUOP_W'(ALU_ADD);
          irWrite = memReady;
          pcWrite = memReady;
        end
        S_DECODE: begin
          aluSrcB   = SRCB_IMMSH;
          aluOp     = ALUOP_W'(ALU_ADD);
          illegalOp = w_op_illegal;
        end
        S_REXEC: begin
          aluSrcA = 1'b1;
          aluOp   = w_funct_alu_op;
        end
        S_IEXEC, S_MEMADDR: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_IMM;
          aluOp   = ALUOP_W'(ALU_ADD);
        end
        S_RWB: begin
          regDst    = 1'b1;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_IWB: begin
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_MEMRD: begin
          memRead = 1'b1;
          iorD    = 1'b1;
        end
        S_MEMWR: begin
          memWrite  = 1'b1;
          iorD      = 1'b1;
          instrDone = memReady;
        end
        S_LWB: begin
          regWrite  = 1'b1;
          memToReg  = 1'b1;
          instrDone = 1'b1;
        end
        S_BRANCH: begin
          aluSrcA     = 1'b1;
          aluOp       = ALUOP_W'(ALU_SUB);
          pcWriteCond = 1'b1;
          pcSource    = PCSRC_ALUOUT;
          branchNe    = (opcode == OPCODE_W'(OP_BNE));
          instrDone   = 1'b1;
        end
        S_JUMP: begin
          pcWrite   = 1'b1;
          pcSource  = PCSRC_JUMP;
          instrDone = 1'b1;
        end
        default: ;
      endcase
    end
    memReq = memRead | memWrite;
  end

endmodule

// File: tb/tb_multicycle_controls.sv
// Bench for multicycle_controls: per-instruction expected cycle traces built
// from the instruction-class timing rules, compared cycle by cycle.
module tb_multicycle_controls;

  typedef struct packed {
    logic       memReq;
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       irWrite;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       branchNe;
    logic [1:0] pcSource;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [3:0] aluOp;
    logic       regDst;
    logic       regWrite;
    logic       memToReg;
    logic       illegalOp;
    logic       instrDone;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       memReady;
  logic       memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, branchNe;
  logic [1:0] pcSource;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [3:0] aluOp;
  logic       regDst, regWrite, memToReg, illegalOp, instrDone;
  out_t       w_act;

  int n_checks = 0;
  int n_errors = 0;

  out_t exp_q[$];
  bit   rdy_q[$];

  always #5 clk = ~clk;

  multicycle_controls #(.OPCODE_W(6), .FUNCT_W(6), .ALUOP_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .memReady    (memReady),
    .memReq      (memReq),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .iorD        (iorD),
    .irWrite     (irWrite),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .branchNe    (branchNe),
    .pcSource    (pcSource),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluOp       (aluOp),
    .regDst      (regDst),
    .regWrite    (regWrite),
    .memToReg    (memToReg),
    .illegalOp   (illegalOp),
    .instrDone   (instrDone)
  );

  assign w_act = {memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, branchNe,
                  pcSource, aluSrcA, aluSrcB, aluOp, regDst, regWrite, memToReg, illegalOp,
                  instrDone};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %06h expected %06h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] r_alu_code(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    return op inside {6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
  endfunction

  task automatic push(input out_t o, input bit rdy);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
  endtask

  // Expected trace: fw fetch wait cycles, mw data-memory wait cycles.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    out_t o;
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i <= fw; i++) begin
      o = '0;
      o.memReq = 1'b1; o.memRead = 1'b1; o.aluSrcB = 2'b01; o.aluOp = 4'b0010;
      o.irWrite = (i == fw); o.pcWrite = (i == fw);
      push(o, i == fw);
    end
    o = '0;
    o.aluSrcB = 2'b11; o.aluOp = 4'b0010;
    o.illegalOp = !legal(op, fn);
    push(o, 1'($urandom_range(0, 1)));
    if (!legal(op, fn)) return;
    o = '0;
    case (op)
      6'h00: begin
        o.aluSrcA = 1'b1; o.aluOp = r_alu_code(fn);
        push(o, 1'($urandom_range(0, 1)));
        o = '0; o.regDst = 1'b1; o.regWrite = 1'b1; o.instrDone = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
      end
      6'h08: begin
        o.aluSrcA = 1'b1; o.aluSrcB = 2'b10; o.aluOp = 4'b0010;
        push(o, 1'($urandom_range(0, 1)));
        o = '0; o.regWrite = 1'b1; o.instrDone = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
      end
      6'h23, 6'h2B: begin
        o.aluSrcA = 1'b1; o.aluSrcB = 2'b10; o.aluOp = 4'b0010;
        push(o, 1'($urandom_range(0, 1)));
        for (int i = 0; i <= mw; i++) begin
          o = '0;
          o.memReq = 1'b1; o.iorD = 1'b1;
          if (op == 6'h23) o.memRead = 1'b1;
          else begin
            o.memWrite = 1'b1;
            o.instrDone = (i == mw);
          end
          push(o, i == mw);
        end
        if (op == 6'h23) begin
          o = '0; o.regWrite = 1'b1; o.memToReg = 1'b1; o.instrDone = 1'b1;
          push(o, 1'($urandom_range(0, 1)));
        end
      end
      6'h04, 6'h05: begin
        o.aluSrcA = 1'b1; o.aluOp = 4'b0110; o.pcWriteCond = 1'b1; o.pcSource = 2'b01;
        o.branchNe = (op == 6'h05); o.instrDone = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
      end
      default: begin
        o.pcWrite = 1'b1; o.pcSource = 2'b10; o.instrDone = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
      end
    endcase
  endtask

  // Play one instruction; abort_at >= 0 asserts reset in that cycle instead.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                     input int abort_at);
    build(op, fn, fw, mw);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n    = (i == abort_at) ? 1'b0 : 1'b1;
      opcode   = op;
      funct    = fn;
      memReady = rdy_q[i];
      @(negedge clk);
      if (i == abort_at) begin
        chk($sformatf("reset_abort op%02h cyc%0d", op, i), 32'(w_act), 32'd0);
        return;
      end
      chk($sformatf("op%02h fn%02h cyc%0d", op, fn, i), 32'(w_act), 32'(exp_q[i]));
    end
  endtask

  logic [5:0] legal_ops [7];
  logic [5:0] bad_ops   [6];
  logic [5:0] r_fns     [5];

  initial begin
    legal_ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    bad_ops   = '{6'h01, 6'h03, 6'h06, 6'h10, 6'h22, 6'h3F};
    r_fns     = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    rst_n    = 1'b0;
    memReady = 1'b1;
    opcode   = 6'h00;
    funct    = 6'h20;
    repeat (2) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_outputs", 32'(w_act), 32'd0);
    end

    run(6'h00, 6'h20, 0, 0, -1);   // ADD zero-wait
    run(6'h23, 6'h00, 0, 3, -1);   // LW with 3 data wait cycles
    run(6'h05, 6'h00, 0, 0, -1);   // BNE
    run(6'h04, 6'h00, 0, 0, -1);   // BEQ
    run(6'h3F, 6'h20, 0, 0, -1);   // illegal opcode
    run(6'h00, 6'h3F, 0, 0, -1);   // illegal funct
    run(6'h2B, 6'h00, 0, 3, 4);    // SW, reset during second data wait cycle
    run(6'h00, 6'h2A, 0, 0, -1);   // SLT right after reset release
    run(6'h2B, 6'h00, 2, 0, -1);   // SW with fetch wait
    run(6'h08, 6'h00, 1, 0, -1);   // ADDI
    run(6'h02, 6'h00, 0, 0, -1);   // J
    run(6'h00, 6'h22, 0, 0, -1);   // SUB

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7) op = legal_ops[sel];
      else         op = bad_ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
      else                           fn = r_fns[$urandom_range(0, 4)];
      if ($urandom_range(0, 15) == 0 && (op == 6'h23 || op == 6'h2B))
        run(op, fn, $urandom_range(0, 2), 2, 3 + $urandom_range(0, 2));
      else
        run(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
